// File: rtl/rx_deframer.sv
// Receive deframer: hunts for the sync word, then reassembles MSB-first payload bytes into an AXI-Stream byte stream.
// Optional RX_DEFRAMER_INV_SYNC_EN also accepts the inverted sync word and inverts the payload (BPSK phase ambiguity).
module rx_deframer #(
    parameter int                    SYNC_WIDTH  = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD   = 16'hEB90,
    parameter int                    FRAME_BYTES = 16,
    parameter int                    LOCK_MISS   = 3
) (
    input  logic        clk_32M768,
    input  logic        rst_n_32M768,
    input  logic        rx_bit,
    input  logic        rx_bit_valid,
    output logic [7:0]  data_tdata,
    output logic        data_tvalid,
    input  logic        data_tready,
    output logic        data_tlast,
    output logic        data_tuser,
    output logic        locked,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {HUNT, PAYLOAD, VERIFY} state_t;

    localparam logic [5:0] SW_LEN    = 6'(SYNC_WIDTH);
    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);
    localparam logic [3:0] MISS_MAX  = 4'(LOCK_MISS);

    state_t                  state_q, state_d;
    logic [SYNC_WIDTH-1:0]   sr_q, sr_d;
    logic [5:0]              fill_q, fill_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              byte_cnt_q, byte_cnt_d;
    logic [3:0]              miss_q, miss_d;
    logic                    locked_q, locked_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [7:0]              tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    tuser_q, tuser_d;
    logic                    ovf_q, ovf_d;

    logic [SYNC_WIDTH-1:0]   sr_shift;
    logic [SYNC_WIDTH-1:0]   verify_word;
    logic [7:0]              rx_byte;
    logic                    hunt_full;
    logic                    byte_push, push_first, push_last;

    assign sr_shift  = {sr_q[SYNC_WIDTH-2:0], rx_bit};
    assign hunt_full = (fill_q >= SW_LEN - 6'd1);

`ifdef RX_DEFRAMER_INV_SYNC_EN
    logic pol_q, pol_d;
    assign verify_word = pol_q ? ~SYNC_WORD : SYNC_WORD;
    assign rx_byte     = sr_shift[7:0] ^ {8{pol_q}};
`else
    assign verify_word = SYNC_WORD;
    assign rx_byte     = sr_shift[7:0];
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        frame_cnt_d = frame_cnt_q;
`ifdef RX_DEFRAMER_INV_SYNC_EN
        pol_d       = pol_q;
`endif
        byte_push   = 1'b0;
        push_first  = 1'b0;
        push_last   = 1'b0;

        if (rx_bit_valid) begin
            sr_d = sr_shift;
            unique case (state_q)
                HUNT: begin
                    if (fill_q != SW_LEN) fill_d = fill_q + 6'd1;
                    if (hunt_full && sr_shift == SYNC_WORD) begin
                        state_d     = PAYLOAD;
                        locked_d    = 1'b1;
                        miss_d      = 4'd0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        bit_cnt_d   = 6'd0;
                        byte_cnt_d  = 8'd0;
`ifdef RX_DEFRAMER_INV_SYNC_EN
                        pol_d       = 1'b0;
                    end else if (hunt_full && sr_shift == ~SYNC_WORD) begin
                        state_d     = PAYLOAD;
                        locked_d    = 1'b1;
                        miss_d      = 4'd0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        bit_cnt_d   = 6'd0;
                        byte_cnt_d  = 8'd0;
                        pol_d       = 1'b1;
`endif
                    end
                end
                PAYLOAD: begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d  = 6'd0;
                        byte_push  = 1'b1;
                        push_first = (byte_cnt_q == 8'd0);
                        push_last  = (byte_cnt_q == LAST_BYTE);
                        if (push_last) begin
                            state_d    = VERIFY;
                            byte_cnt_d = 8'd0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end
                VERIFY: begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == SW_LEN - 6'd1) begin
                        bit_cnt_d = 6'd0;
                        if (sr_shift == verify_word) begin
                            miss_d      = 4'd0;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            state_d     = PAYLOAD;
                        end else if (miss_q + 4'd1 == MISS_MAX) begin
                            miss_d   = MISS_MAX;
                            locked_d = 1'b0;
                            state_d  = HUNT;
                            fill_d   = 6'd0;
`ifdef RX_DEFRAMER_INV_SYNC_EN
                            pol_d    = 1'b0;
`endif
                        end else begin
                            // Flywheel: keep frame timing through an isolated miss
                            miss_d  = miss_q + 4'd1;
                            state_d = PAYLOAD;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Single-entry output register; a byte landing on a stalled slot is dropped
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        ovf_d    = 1'b0;
        if (tvalid_q && data_tready) tvalid_d = 1'b0;
        if (byte_push) begin
            if (!tvalid_q || data_tready) begin
                tdata_d  = rx_byte;
                tuser_d  = push_first;
                tlast_d  = push_last;
                tvalid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            frame_cnt_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef RX_DEFRAMER_INV_SYNC_EN
            pol_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            frame_cnt_q <= frame_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            ovf_q       <= ovf_d;
`ifdef RX_DEFRAMER_INV_SYNC_EN
            pol_q       <= pol_d;
`endif
        end
    end

    assign data_tdata  = tdata_q;
    assign data_tvalid = tvalid_q;
    assign data_tlast  = tlast_q;
    assign data_tuser  = tuser_q;
    assign locked      = locked_q;
    assign overflow    = ovf_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: frame table, stall/overflow and back-to-back sequences, random stream vs. index-arithmetic model.
module tb_rx_deframer;
    localparam int W    = 16;
    localparam int F    = 16;
    localparam int LM   = 3;
    localparam int SWI  = 'hEB90;
    localparam int SWN  = 'h146F;

    logic        clk = 1'b0, rst_n = 1'b0, rx_bit = 1'b0, rx_bit_valid = 1'b0, tready = 1'b1;
    logic [7:0]  tdata;
    logic        tvalid, tlast, tuser, locked, ovf;
    logic [15:0] fcnt;

    always #5 clk = ~clk;

    rx_deframer dut (
        .clk_32M768(clk), .rst_n_32M768(rst_n), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
        .data_tdata(tdata), .data_tvalid(tvalid), .data_tready(tready), .data_tlast(tlast),
        .data_tuser(tuser), .locked(locked), .overflow(ovf), .frame_cnt(fcnt)
    );

    int n_pass = 0, n_tot = 0;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Handshake monitor, sampled mid-cycle
    typedef struct packed {logic u; logic l; logic [7:0] d;} ob_t;
    ob_t  outq[$];
    int   cycq[$];
    int   cyc = 0, ovf_cnt = 0, hold_viol = 0;
    logic hold_prev = 1'b0;
    logic [10:0] hold_val = '0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (tvalid && tready) begin outq.push_back({tuser, tlast, tdata}); cycq.push_back(cyc); end
        if (ovf) ovf_cnt++;
        if (hold_prev && {tvalid, tuser, tlast, tdata} != hold_val) hold_viol++;
        hold_prev = tvalid && !tready;
        hold_val  = {tvalid, tuser, tlast, tdata};
    end

    task automatic step(input logic v, input logic b);
        rx_bit_valid = v; rx_bit = b;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [15:0] w, input int nb, input int gap);
        for (int i = nb - 1; i >= 0; i--) begin
            step(1'b1, w[i]);
            repeat (gap) step(1'b0, 1'b0);
        end
        rx_bit_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_bit_valid = 1'b0; rx_bit = 1'b0; tready = 1'b1; rst_n = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        outq.delete(); cycq.delete(); ovf_cnt = 0; hold_viol = 0;
    endtask

    // Reference model: frame positions derived by index arithmetic over the whole bit stream
    bit          bits[$];
    int          lk_ev[], fc_ev[];
    bit          bv[];
    logic [9:0]  bd[];

    function automatic int win(input int j);
        int w = 0;
        for (int t = j - W + 1; t <= j; t++) w = (w << 1) | int'(bits[t]);
        return w;
    endfunction

    function automatic logic [7:0] byte_at(input int e);
        logic [7:0] r = '0;
        for (int t = 0; t < 8; t++) r[7-t] = bits[e-7+t];
        return r;
    endfunction

    task automatic run_model();
        int n, s, j, v, fc, miss, e, expw;
        bit pol, found, done;
        n = bits.size();
        lk_ev = new[n]; fc_ev = new[n]; bv = new[n]; bd = new[n];
        for (int k = 0; k < n; k++) begin lk_ev[k] = -1; fc_ev[k] = -1; bv[k] = 1'b0; bd[k] = '0; end
        s = 0; fc = 0; done = 1'b0;
        while (!done) begin
            found = 1'b0; pol = 1'b0; j = 0;
            for (int t = s + W - 1; t < n && !found; t++) begin
                if (win(t) == SWI) begin found = 1'b1; j = t; end
`ifdef RX_DEFRAMER_INV_SYNC_EN
                else if (win(t) == SWN) begin found = 1'b1; pol = 1'b1; j = t; end
`endif
            end
            if (!found) done = 1'b1;
            else begin
                fc++; lk_ev[j] = 1; fc_ev[j] = fc; miss = 0;
                while (!done) begin
                    for (int b = 0; b < F; b++) begin
                        e = j + 8 * (b + 1);
                        if (e < n) begin
                            bv[e] = 1'b1;
                            bd[e] = {1'(b == 0), 1'(b == F - 1), byte_at(e) ^ (pol ? 8'hFF : 8'h00)};
                        end
                    end
                    v = j + 8 * F + W;
                    expw = pol ? SWN : SWI;
                    if (v >= n) done = 1'b1;
                    else if (win(v) == expw) begin fc++; fc_ev[v] = fc; miss = 0; j = v; end
                    else begin
                        miss++;
                        if (miss == LM) begin lk_ev[v] = 0; s = v + 1; break; end
                        j = v;
                    end
                end
            end
        end
    endtask

    typedef struct {
        logic [15:0] sync; logic [7:0] base; bit incr; bit inv;
        bit exp_out; bit exp_lk; int exp_fc;
    } row_t;

    initial begin
        row_t        rows[11];
        logic [7:0]  pb, eb;
        ob_t         exp_ob;
        ob_t         expq[$];
        bit          sq[$];
        int          cur_lk, cur_fc, g, c, nb;
        logic [15:0] sw;

        rows[0]  = '{16'hEB90, 8'h00, 1, 0, 1, 1, 1};
        rows[1]  = '{16'hEB91, 8'h10, 1, 0, 1, 1, 1};
        rows[2]  = '{16'hEB90, 8'h20, 1, 0, 1, 1, 2};
        rows[3]  = '{16'hEB91, 8'h30, 1, 0, 1, 1, 2};
        rows[4]  = '{16'hEB91, 8'h40, 1, 0, 1, 1, 2};
        rows[5]  = '{16'hEB91, 8'h00, 0, 0, 0, 0, 2};
        rows[6]  = '{16'hEB90, 8'h70, 1, 0, 1, 1, 3};
        rows[7]  = '{16'hEB91, 8'h00, 0, 0, 1, 1, 3};
        rows[8]  = '{16'hEB91, 8'h00, 0, 0, 1, 1, 3};
        rows[9]  = '{16'hEB91, 8'h00, 0, 0, 0, 0, 3};
`ifdef RX_DEFRAMER_INV_SYNC_EN
        rows[10] = '{16'h146F, 8'h00, 1, 1, 1, 1, 4};
`else
        rows[10] = '{16'h146F, 8'h00, 1, 1, 0, 0, 3};
`endif

        // Reset state and sparse strobes that can never fill the sync window
        do_reset();
        chk("reset_outputs", {tvalid, tlast, tuser, locked, ovf, tdata, fcnt}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'($urandom));
            repeat (31) step(1'b0, 1'b0);
        end
        chk("sparse_bits_state", {tvalid, locked, ovf, fcnt}, 32'h0);
        chk("sparse_bits_noout", outq.size() + ovf_cnt, 0);

        // Frame table
        do_reset();
        send_word(16'($urandom), 5, 1);
        for (int r = 0; r < 11; r++) begin
            outq.delete();
            for (int k = W - 1; k >= 0; k--) begin
                step(1'b1, rows[r].sync[k]);
                if (r == 0 && k == 1) chk("lock_before_last_sync_bit", locked, 0);
                if (r == 0 && k == 0) chk("lock_after_last_sync_bit", locked, 1);
                step(1'b0, 1'b0);
            end
            for (int b = 0; b < F; b++) begin
                eb = rows[r].base + (rows[r].incr ? 8'(b) : 8'h00);
                pb = eb ^ (rows[r].inv ? 8'hFF : 8'h00);
                send_word({8'h00, pb}, 8, 1);
            end
            repeat (2) step(1'b0, 1'b0);
            chk($sformatf("row%0d_locked", r), locked, 32'(rows[r].exp_lk));
            chk($sformatf("row%0d_frame_cnt", r), fcnt, rows[r].exp_fc);
            chk($sformatf("row%0d_nbytes", r), outq.size(), rows[r].exp_out ? F : 0);
            if (rows[r].exp_out)
                for (int b = 0; b < F && b < outq.size(); b++) begin
                    exp_ob = {1'(b == 0), 1'(b == F - 1), 8'(rows[r].base + (rows[r].incr ? 8'(b) : 8'h00))};
                    chk($sformatf("row%0d_byte%0d", r, b), outq[b], exp_ob);
                end
        end

        // Stall for 20 bit times: byte 0 held, byte 1 dropped, alignment kept
        do_reset();
        sq.delete();
        for (int i = 15; i >= 0; i--) sq.push_back(SWI[i]);
        for (int b = 0; b < F; b++) for (int i = 7; i >= 0; i--) sq.push_back(b[i]);
        for (int i = 15; i >= 0; i--) sq.push_back(SWI[i]);
        for (int b = 0; b < F; b++) for (int i = 7; i >= 0; i--) sq.push_back(b[i]);
        for (int i = 0; i < sq.size(); i++) begin
            if (i == W) tready = 1'b0;
            if (i == W + 20) begin
                chk("stall_held_byte", {tvalid, tuser, tlast, tdata}, {1'b1, 1'b1, 1'b0, 8'h00});
                chk("stall_ovf_pulses", ovf_cnt, 1);
                chk("stall_hold_stable", hold_viol, 0);
                chk("stall_no_handshake", outq.size(), 0);
                tready = 1'b1;
            end
            step(1'b1, sq[i]);
            step(1'b0, 1'b0);
        end
        repeat (2) step(1'b0, 1'b0);
        expq.delete();
        expq.push_back({1'b1, 1'b0, 8'h00});
        for (int b = 2; b < F; b++) expq.push_back({1'b0, 1'(b == F - 1), 8'(b)});
        for (int b = 0; b < F; b++) expq.push_back({1'(b == 0), 1'(b == F - 1), 8'(b)});
        chk("stall_nbytes", outq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < outq.size(); i++)
            chk($sformatf("stall_byte%0d", i), outq[i], expq[i]);
        chk("stall_frame_cnt", fcnt, 2);
        chk("stall_ovf_total", ovf_cnt, 1);

        // Back-to-back strobes
        do_reset();
        send_word(16'hEB90, 16, 0);
        for (int b = 0; b < F; b++) send_word(16'h00A5, 8, 0);
        repeat (3) step(1'b0, 1'b0);
        chk("b2b_nbytes", outq.size(), F);
        for (int b = 0; b < F && b < outq.size(); b++) begin
            chk($sformatf("b2b_byte%0d", b), outq[b], {1'(b == 0), 1'(b == F - 1), 8'hA5});
            if (b > 0) chk($sformatf("b2b_spacing%0d", b), cycq[b] - cycq[b-1], 8);
        end
        chk("b2b_ovf", ovf_cnt, 0);

        // Random stream against the model, gaps 0..2
        do_reset();
        bits.delete();
        for (int u = 0; u < 14; u++) begin
            c = $urandom_range(0, 9);
            if (c == 0) begin
                nb = $urandom_range(1, 24);
                for (int i = 0; i < nb; i++) bits.push_back(1'($urandom));
            end else begin
                sw = 16'(SWI);
                if (c <= 2) sw = sw ^ (16'h1 << $urandom_range(0, 15));
                if (c == 9) sw = 16'(SWN);
                for (int i = 15; i >= 0; i--) bits.push_back(sw[i]);
                for (int i = 0; i < 8 * F; i++) bits.push_back(1'($urandom));
            end
        end
        run_model();
        cur_lk = 0; cur_fc = 0;
        for (int k = 0; k < bits.size(); k++) begin
            step(1'b1, bits[k]);
            if (lk_ev[k] >= 0) cur_lk = lk_ev[k];
            if (fc_ev[k] >= 0) cur_fc = fc_ev[k];
            chk($sformatf("rand_bit%0d", k),
                {3'b0, locked, fcnt, tvalid, ovf, (tvalid ? {tuser, tlast, tdata} : 10'h0)},
                {3'b0, 1'(cur_lk), 16'(cur_fc), bv[k], 1'b0, (bv[k] ? bd[k] : 10'h0)});
            g = $urandom_range(0, 2);
            repeat (g) step(1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
